// File: rtl/counter_request_arbiter.sv
// Counter-increment request arbiter.
// Collects single-cycle PINC/MINC pulses from the counter cells into a
// per-cell pending table, presents the highest-priority pending request to
// the CPU over a valid/ack handshake, and forces a one-cycle yield after
// MAX_STEAL consecutive grants so the instruction pipeline is not starved.
module counter_request_arbiter #(
  parameter int NUM_CNT   = 8,
  parameter int MAX_STEAL = 3,
  localparam int CW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [NUM_CNT-1:0] pinc,
  input  logic [NUM_CNT-1:0] minc,
  input  logic               svc_ack,
  output logic               req_valid,
  output logic [CW-1:0]      req_cnt,
  output logic               req_dir,
  output logic               stall,
  output logic [NUM_CNT-1:0] pending,
  output logic               overflow_err
);

  localparam int SW = $clog2(MAX_STEAL + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    YIELD = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SW-1:0]      steal_cnt;
  logic [SW-1:0]      steal_nxt;

  // A cell holds at most one outstanding request: plus, minus, or none.
  logic [NUM_CNT-1:0] pend_plus;
  logic [NUM_CNT-1:0] pend_minus;
  logic [NUM_CNT-1:0] plus_nxt;
  logic [NUM_CNT-1:0] minus_nxt;
  logic               ovf_set;

  logic               any_pend;
  logic [CW-1:0]      sel_idx;
  logic               load;

  assign pending   = pend_plus | pend_minus;
  assign any_pend  = |pending;
  assign req_valid = (state == GRANT);
  assign stall     = req_valid;

  // Priority select: lowest-index pending cell wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CNT - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = CW'(i);
    end
  end

  // Next state, steal counter and request-load decision.
  always_comb begin
    state_nxt = state;
    steal_nxt = steal_cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (any_pend) begin
          load      = 1'b1;
          steal_nxt = SW'(1);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (svc_ack) begin
          if (steal_cnt == SW'(MAX_STEAL)) begin
            state_nxt = YIELD;
            steal_nxt = '0;
          end else if (any_pend) begin
            load      = 1'b1;
            steal_nxt = steal_cnt + SW'(1);
          end else begin
            state_nxt = IDLE;
            steal_nxt = '0;
          end
        end
      end
      YIELD: begin
        if (any_pend) begin
          load      = 1'b1;
          steal_nxt = SW'(1);
          state_nxt = GRANT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        steal_nxt = '0;
      end
    endcase
  end

  // Table update: clear the cell being granted, then fold in this cycle's pulses.
  always_comb begin
    plus_nxt  = pend_plus;
    minus_nxt = pend_minus;
    ovf_set   = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (load && (sel_idx == CW'(i))) begin
        plus_nxt[i]  = 1'b0;
        minus_nxt[i] = 1'b0;
      end
      // Simultaneous +1 and -1 nets to zero and leaves the cell alone.
      if (pinc[i] && !minc[i]) begin
        if (minus_nxt[i])     minus_nxt[i] = 1'b0;
        else if (plus_nxt[i]) ovf_set      = 1'b1;
        else                  plus_nxt[i]  = 1'b1;
      end else if (minc[i] && !pinc[i]) begin
        if (plus_nxt[i])       plus_nxt[i]  = 1'b0;
        else if (minus_nxt[i]) ovf_set      = 1'b1;
        else                   minus_nxt[i] = 1'b1;
      end
    end
  end

  // FSM state and steal counter registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      steal_cnt <= '0;
    end else begin
      state     <= state_nxt;
      steal_cnt <= steal_nxt;
    end
  end

  // Pending table and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend_plus    <= '0;
      pend_minus   <= '0;
      overflow_err <= 1'b0;
    end else begin
      pend_plus  <= plus_nxt;
      pend_minus <= minus_nxt;
      if (ovf_set) overflow_err <= 1'b1;
    end
  end

  // Presented request; only changes when a new grant is loaded.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      req_cnt <= '0;
      req_dir <= 1'b0;
    end else if (load) begin
      req_cnt <= sel_idx;
      req_dir <= pend_minus[sel_idx];
    end
  end

endmodule

// File: tb/tb_counter_request_arbiter.sv
// Bench for counter_request_arbiter: directed stimulus with an expected-grant
// queue drained by an independent handshake monitor.
module tb_counter_request_arbiter;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic [7:0] pinc = 8'h00;
  logic [7:0] minc = 8'h00;
  logic       svc_ack = 1'b0;
  logic       req_valid;
  logic [2:0] req_cnt;
  logic       req_dir;
  logic       stall;
  logic [7:0] pending;
  logic       overflow_err;

  typedef struct packed {
    logic [2:0] cnt;
    logic       dir;
  } req_t;

  req_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  counter_request_arbiter #(.NUM_CNT(8), .MAX_STEAL(3)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .pinc         (pinc),
    .minc         (minc),
    .svc_ack      (svc_ack),
    .req_valid    (req_valid),
    .req_cnt      (req_cnt),
    .req_dir      (req_dir),
    .stall        (stall),
    .pending      (pending),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int cnt, input int dir);
    req_t r;
    r.cnt = 3'(cnt);
    r.dir = 1'(dir);
    exp_q.push_back(r);
  endtask

  // Monitor: every completed handshake must match the next expected grant.
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (rst_l && req_valid && svc_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got cnt=%0d dir=%0d required no grant", req_cnt, req_dir);
        end else begin
          e = exp_q.pop_front();
          chk("sb_cnt", int'(req_cnt), int'(e.cnt));
          chk("sb_dir", int'(req_dir), int'(e.dir));
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end

  // Cycle-by-cycle expectations for the steal-cap burst.
  int cap_vld[7] = '{1, 1, 1, 0, 1, 1, 0};
  int cap_cnt[7] = '{0, 1, 2, 0, 3, 4, 0};
  int cap_dir[7] = '{0, 1, 0, 0, 1, 0, 0};

  initial begin
    // Reset state
    step();
    chk("rst_valid", int'(req_valid), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_ovf", int'(overflow_err), 0);
    rst_l = 1'b1;
    step();

    // 1: single plus request, latency and ack
    pinc = 8'h20;
    step();
    pinc = 8'h00;
    chk("t1_pending", int'(pending), 'h20);
    chk("t1_valid_c1", int'(req_valid), 0);
    push(5, 0);
    step();
    chk("t1_valid_c2", int'(req_valid), 1);
    chk("t1_stall_c2", int'(stall), 1);
    chk("t1_cnt", int'(req_cnt), 5);
    chk("t1_dir", int'(req_dir), 0);
    chk("t1_pending_c2", int'(pending), 0);
    step();
    step();
    svc_ack = 1'b1;
    step();
    svc_ack = 1'b0;
    chk("t1_valid_c5", int'(req_valid), 0);
    chk("t1_pending_c5", int'(pending), 0);
    step();

    // 2: two simultaneous requests served back-to-back
    pinc = 8'h40;
    minc = 8'h04;
    step();
    pinc = 8'h00;
    minc = 8'h00;
    chk("t2_pending", int'(pending), 'h44);
    push(2, 1);
    push(6, 0);
    step();
    chk("t2_cnt_a", int'(req_cnt), 2);
    chk("t2_dir_a", int'(req_dir), 1);
    svc_ack = 1'b1;
    step();
    chk("t2_stall_b", int'(stall), 1);
    chk("t2_cnt_b", int'(req_cnt), 6);
    chk("t2_dir_b", int'(req_dir), 0);
    step();
    svc_ack = 1'b0;
    chk("t2_idle", int'(req_valid), 0);
    step();

    // 3a: cancel on cell 3 while cell 0 holds the grant
    pinc = 8'h01;
    step();
    pinc = 8'h00;
    step();
    chk("t3a_busy_cnt", int'(req_cnt), 0);
    push(0, 0);
    pinc = 8'h08;
    step();
    pinc = 8'h00;
    chk("t3a_pend_plus", int'(pending), 'h08);
    minc = 8'h08;
    step();
    minc = 8'h00;
    chk("t3a_cancelled", int'(pending), 0);
    chk("t3a_ovf", int'(overflow_err), 0);
    svc_ack = 1'b1;
    step();
    svc_ack = 1'b0;
    chk("t3a_idle", int'(req_valid), 0);
    step();
    chk("t3a_no_grant", int'(req_valid), 0);

    // 3b: double plus on cell 3 overflows, one grant
    pinc = 8'h01;
    step();
    pinc = 8'h00;
    step();
    chk("t3b_busy_cnt", int'(req_cnt), 0);
    push(0, 0);
    pinc = 8'h08;
    step();
    chk("t3b_ovf_first", int'(overflow_err), 0);
    step();
    pinc = 8'h00;
    chk("t3b_ovf", int'(overflow_err), 1);
    chk("t3b_pending", int'(pending), 'h08);
    push(3, 0);
    svc_ack = 1'b1;
    step();
    chk("t3b_cnt3", int'(req_cnt), 3);
    chk("t3b_valid3", int'(req_valid), 1);
    step();
    svc_ack = 1'b0;
    chk("t3b_idle", int'(req_valid), 0);
    step();
    step();
    chk("t3b_ovf_sticky", int'(overflow_err), 1);
    chk("t3b_pending_end", int'(pending), 0);

    // 4: steal cap with five cells pending and continuous ack
    pinc = 8'h15;
    minc = 8'h0A;
    step();
    pinc = 8'h00;
    minc = 8'h00;
    chk("t4_pending", int'(pending), 'h1F);
    push(0, 0);
    push(1, 1);
    push(2, 0);
    push(3, 1);
    push(4, 0);
    svc_ack = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("t4_valid_%0d", k), int'(req_valid), cap_vld[k]);
      chk($sformatf("t4_stall_%0d", k), int'(stall), cap_vld[k]);
      if (cap_vld[k] == 1) begin
        chk($sformatf("t4_cnt_%0d", k), int'(req_cnt), cap_cnt[k]);
        chk($sformatf("t4_dir_%0d", k), int'(req_dir), cap_dir[k]);
      end
    end
    svc_ack = 1'b0;
    step();

    // 5: long hold on cell 1, retrigger during the grant
    pinc = 8'h02;
    step();
    pinc = 8'h00;
    step();
    push(1, 0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t5_hold_valid_%0d", k), int'(req_valid), 1);
      chk($sformatf("t5_hold_cnt_%0d", k), int'(req_cnt), 1);
      chk($sformatf("t5_hold_dir_%0d", k), int'(req_dir), 0);
      if (k == 1) pinc = 8'h02;
      step();
      pinc = 8'h00;
    end
    chk("t5_retrig_pending", int'(pending), 'h02);
    push(1, 0);
    svc_ack = 1'b1;
    step();
    chk("t5_regrant_valid", int'(req_valid), 1);
    chk("t5_regrant_cnt", int'(req_cnt), 1);
    chk("t5_regrant_pending", int'(pending), 0);
    step();
    svc_ack = 1'b0;
    chk("t5_idle", int'(req_valid), 0);
    step();

    // 6: asynchronous reset in the middle of a grant
    pinc = 8'h01;
    step();
    pinc = 8'h00;
    step();
    chk("t6_granted", int'(req_valid), 1);
    pinc = 8'h1E;
    step();
    pinc = 8'h00;
    chk("t6_pending", int'(pending), 'h1E);
    chk("t6_ovf_before", int'(overflow_err), 1);
    #2;
    rst_l = 1'b0;
    #1;
    chk("t6_rst_valid", int'(req_valid), 0);
    chk("t6_rst_stall", int'(stall), 0);
    chk("t6_rst_cnt", int'(req_cnt), 0);
    chk("t6_rst_dir", int'(req_dir), 0);
    chk("t6_rst_pending", int'(pending), 0);
    chk("t6_rst_ovf", int'(overflow_err), 0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6_after_valid_%0d", k), int'(req_valid), 0);
      chk($sformatf("t6_after_pending_%0d", k), int'(pending), 0);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
